// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: memory port FSM encodings,
// stall vector constants and a saturating counter helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        PORT_IDLE  = 2'd0,
        PORT_FETCH = 2'd1,
        PORT_MEMOP = 2'd2
    } port_state_e;

    localparam int StallW = 6;

    // bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB
    localparam logic [StallW-1:0] STALL_NONE = 6'b000000;
    localparam logic [StallW-1:0] STALL_IF   = 6'b000011;
    localparam logic [StallW-1:0] STALL_ID   = 6'b000111;
    localparam logic [StallW-1:0] STALL_MEM  = 6'b011111;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages/memory port and pipe_ctrl.
// master = core/memory side, slave = pipe_ctrl.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic              if_req;
    logic              mem_req;
    logic              id_stallreq;
    logic              ex_branch;
    logic              port_done;
    logic              port_req;
    logic              port_sel;
    logic              if_done;
    logic              mem_done;
    logic [StallW-1:0] stall;
    logic              flush;

    modport master (
        output if_req, mem_req, id_stallreq, ex_branch, port_done,
        input  port_req, port_sel, if_done, mem_done, stall, flush
    );

    modport slave (
        input  if_req, mem_req, id_stallreq, ex_branch, port_done,
        output port_req, port_sel, if_done, mem_done, stall, flush
    );

endinterface

// File: rtl/pipe_ctrl_mem_port_arb.sv
// mem_port_arb: owns the shared memory port between fetch and load/store,
// tracks fetches made stale by a branch flush, and produces the done strobes.
//
// state       | meaning
// PORT_IDLE   | port free; mandatory gap cycle between accesses
// PORT_FETCH  | instruction fetch owns the port until port_done
// PORT_MEMOP  | load/store owns the port until port_done
module mem_port_arb
    import pipe_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic if_req_i,
    input  logic mem_req_i,
    input  logic port_done_i,
    input  logic flush_i,
    output logic port_req_o,
    output logic port_sel_o,
    output logic if_done_o,
    output logic mem_done_o
);

    port_state_e state_q, state_d;
    logic        kill_q, kill_d;
    logic        port_req_q, port_sel_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= PORT_IDLE;
            kill_q     <= 1'b0;
            port_req_q <= 1'b0;
            port_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            port_req_q <= (state_d != PORT_IDLE);
            port_sel_q <= (state_d == PORT_MEMOP);
        end
    end

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        case (state_q)
            PORT_IDLE: begin
                if (mem_req_i) begin
                    state_d = PORT_MEMOP;
                end else if (if_req_i) begin
                    state_d = PORT_FETCH;
                    kill_d  = flush_i;
                end
            end
            PORT_FETCH: begin
                // The completing access clears kill so the next fetch is never dropped.
                if (port_done_i) begin
                    state_d = PORT_IDLE;
                    kill_d  = 1'b0;
                end else if (flush_i) begin
                    kill_d  = 1'b1;
                end
            end
            PORT_MEMOP: begin
                if (port_done_i) begin
                    state_d = PORT_IDLE;
                end
            end
            default: begin
                state_d = PORT_IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    assign port_req_o = port_req_q;
    assign port_sel_o = port_sel_q;
    assign if_done_o  = (state_q == PORT_FETCH) && port_done_i && !kill_q;
    assign mem_done_o = (state_q == PORT_MEMOP) && port_done_i;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush sequencer around the shared memory port.
// Define PIPE_CTRL_PERF_CNT_EN to add saturating stall-cycle and flush counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o
`endif
);

    logic              if_done;
    logic              mem_done;
    logic [StallW-1:0] stall_c;
    logic              flush_c;

    mem_port_arb u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .if_req_i    (bus.if_req),
        .mem_req_i   (bus.mem_req),
        .port_done_i (bus.port_done),
        .flush_i     (flush_c),
        .port_req_o  (bus.port_req),
        .port_sel_o  (bus.port_sel),
        .if_done_o   (if_done),
        .mem_done_o  (mem_done)
    );

    // Outputs are forced quiet while reset is held, even with requests present.
    always_comb begin
        stall_c = STALL_NONE;
        if (!rst_ni) begin
            stall_c = STALL_NONE;
        end else if (bus.mem_req && !mem_done) begin
            stall_c = STALL_MEM;
        end else if (bus.id_stallreq) begin
            stall_c = STALL_ID;
        end else if (bus.if_req && !if_done) begin
            stall_c = STALL_IF;
        end
    end

    // A branch held in EX by a MEM stall must wait until EX/MEM is released.
    assign flush_c = rst_ni && bus.ex_branch && !stall_c[3];

    assign bus.stall    = stall_c;
    assign bus.flush    = flush_c;
    assign bus.if_done  = if_done;
    assign bus.mem_done = mem_done;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall_c[0]) begin
            stall_cycles_d = sat_inc(stall_cycles_q);
        end
        if (flush_c) begin
            flush_count_d = sat_inc(flush_count_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a transaction-level model checked every cycle
// plus literal expectations on the scenarios of interest.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    pipe_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bus            (bus)
`ifdef PIPE_CTRL_PERF_CNT_EN
        ,
        .stall_cycles_o (stall_cycles),
        .flush_count_o  (flush_count)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: who holds the port (0 none, 1 fetch, 2 load/store) and whether
    // the fetch in flight has been invalidated by a branch.
    int         m_owner = 0;
    bit         m_drop  = 1'b0;
    int         n_owner;
    bit         n_drop;
    logic       e_preq, e_psel, e_ifd, e_memd, e_flush;
    logic [5:0] e_stall;

    initial begin
        forever begin
            @(negedge clk);
            n_owner = m_owner;
            n_drop  = m_drop;
            if (!rst_n) begin
                e_preq = 0; e_psel = 0; e_ifd = 0; e_memd = 0; e_flush = 0;
                e_stall = 6'd0;
                n_owner = 0;
                n_drop  = 1'b0;
            end else begin
                e_preq = (m_owner != 0);
                e_psel = (m_owner == 2);
                e_memd = (m_owner == 2) && bus.port_done;
                e_ifd  = (m_owner == 1) && bus.port_done && !m_drop;
                if (bus.mem_req && !e_memd)      e_stall = 6'b011111;
                else if (bus.id_stallreq)        e_stall = 6'b000111;
                else if (bus.if_req && !e_ifd)   e_stall = 6'b000011;
                else                             e_stall = 6'b000000;
                e_flush = bus.ex_branch && !e_stall[3];
                if (m_owner == 0) begin
                    if (bus.mem_req) n_owner = 2;
                    else if (bus.if_req) begin
                        n_owner = 1;
                        n_drop  = e_flush;
                    end
                end else if (bus.port_done) begin
                    n_owner = 0;
                    n_drop  = 1'b0;
                end else if (m_owner == 1 && e_flush) begin
                    n_drop = 1'b1;
                end
            end
            check("port_req", {31'd0, bus.port_req}, {31'd0, e_preq});
            check("port_sel", {31'd0, bus.port_sel}, {31'd0, e_psel});
            check("if_done",  {31'd0, bus.if_done},  {31'd0, e_ifd});
            check("mem_done", {31'd0, bus.mem_done}, {31'd0, e_memd});
            check("stall",    {26'd0, bus.stall},    {26'd0, e_stall});
            check("flush",    {31'd0, bus.flush},    {31'd0, e_flush});
            @(posedge clk);
            m_owner = n_owner;
            m_drop  = n_drop;
        end
    end

    // Applies one cycle of inputs just after the rising edge, then settles.
    task automatic cyc(input logic rn, input logic ifr, input logic memr,
                       input logic ids, input logic exb, input logic pd);
        @(posedge clk);
        #1;
        rst_n           = rn;
        bus.if_req      = ifr;
        bus.mem_req     = memr;
        bus.id_stallreq = ids;
        bus.ex_branch   = exb;
        bus.port_done   = pd;
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.if_req = 0; bus.mem_req = 0; bus.id_stallreq = 0;
        bus.ex_branch = 0; bus.port_done = 0;

        // reset holds every output low even with requests asserted
        cyc(0, 1, 1, 0, 1, 1);
        check("rst_stall", {26'd0, bus.stall}, 32'h0);
        check("rst_flush", {31'd0, bus.flush}, 32'h0);
        check("rst_preq",  {31'd0, bus.port_req}, 32'h0);
        cyc(1, 0, 0, 0, 0, 0);

        // plain fetch, done 3 cycles after port_req
        cyc(1, 1, 0, 0, 0, 0);
        check("f1_stall", {26'd0, bus.stall}, 32'h03);
        check("f1_preq0", {31'd0, bus.port_req}, 32'h0);
        cyc(1, 1, 0, 0, 0, 0);
        check("f1_preq1", {31'd0, bus.port_req}, 32'h1);
        check("f1_sel",   {31'd0, bus.port_sel}, 32'h0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1);
        check("f1_ifdone", {31'd0, bus.if_done}, 32'h1);
        check("f1_stall0", {26'd0, bus.stall}, 32'h0);
        cyc(1, 0, 0, 0, 0, 0);
        check("f1_preq_lo", {31'd0, bus.port_req}, 32'h0);

        // MEM wins over IF, gap cycle, then fetch
        cyc(1, 1, 1, 0, 0, 0);
        check("p_stall", {26'd0, bus.stall}, 32'h1f);
        cyc(1, 1, 1, 0, 0, 0);
        check("p_sel1", {31'd0, bus.port_sel}, 32'h1);
        cyc(1, 1, 1, 0, 0, 1);
        check("p_memdone", {31'd0, bus.mem_done}, 32'h1);
        check("p_stall_if", {26'd0, bus.stall}, 32'h03);
        cyc(1, 1, 0, 0, 0, 0);
        check("p_gap", {31'd0, bus.port_req}, 32'h0);
        cyc(1, 1, 0, 0, 0, 0);
        check("p_fetch", {30'd0, bus.port_req, bus.port_sel}, 32'h2);
        cyc(1, 1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);

        // mem_req during FETCH waits for the fetch
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        check("w_stall", {26'd0, bus.stall}, 32'h1f);
        cyc(1, 1, 1, 0, 0, 1);
        check("w_ifdone", {31'd0, bus.if_done}, 32'h1);
        check("w_stall2", {26'd0, bus.stall}, 32'h1f);
        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        check("w_memop", {31'd0, bus.port_sel}, 32'h1);
        cyc(1, 1, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);

        // branch during FETCH kills the fetch, next fetch delivered
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 0);
        check("k_flush", {31'd0, bus.flush}, 32'h1);
        cyc(1, 1, 0, 0, 0, 0);
        check("k_flush0", {31'd0, bus.flush}, 32'h0);
        cyc(1, 1, 0, 0, 0, 1);
        check("k_dropped", {31'd0, bus.if_done}, 32'h0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1);
        check("k_next", {31'd0, bus.if_done}, 32'h1);
        cyc(1, 0, 0, 0, 0, 0);

        // branch held behind a pending load/store
        cyc(1, 0, 1, 0, 1, 0);
        check("b_hold0", {31'd0, bus.flush}, 32'h0);
        cyc(1, 0, 1, 0, 1, 0);
        check("b_hold1", {31'd0, bus.flush}, 32'h0);
        cyc(1, 0, 1, 0, 1, 1);
        check("b_release", {31'd0, bus.flush}, 32'h1);
        cyc(1, 0, 0, 0, 0, 0);

        // flush in the same cycle a fetch starts
        cyc(1, 1, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1);
        check("s_dropped", {31'd0, bus.if_done}, 32'h0);
        cyc(1, 0, 0, 0, 0, 0);

        // load-use hazard together with a branch
        cyc(1, 0, 0, 1, 1, 0);
        check("h_stall", {26'd0, bus.stall}, 32'h07);
        check("h_flush", {31'd0, bus.flush}, 32'h1);
        cyc(1, 0, 0, 0, 0, 0);

        // reset in the middle of a fetch; outstanding done is ignored
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1);
        check("r_preq", {31'd0, bus.port_req}, 32'h0);
        check("r_ifdone", {31'd0, bus.if_done}, 32'h0);
        check("r_stall", {26'd0, bus.stall}, 32'h0);
        cyc(1, 0, 0, 0, 0, 0);
        check("r_idle", {31'd0, bus.port_req}, 32'h0);

`ifdef PIPE_CTRL_PERF_CNT_EN
        check("c_zero", stall_cycles, 32'd0);
        // 10 stalled cycles, then 2 flushes
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("c_stall", stall_cycles, 32'd10);
        check("c_flush", flush_count, 32'd2);
        cyc(0, 0, 0, 0, 0, 0);
        check("c_rst", stall_cycles | flush_count, 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
`endif

        cyc(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencer for the five-stage RISC-V core. Arbitrates the single shared memory port between instruction fetch (IF) and load/store (MEM), and derives the 6-bit `stall` vector consumed by PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Also generates the branch `flush` and discards fetches made stale by a taken branch. Sits beside the stage registers and drives their `stall` and `flush` inputs.

## Interface
- Parameters: none; all widths come from the shared defines (`RegBus`/`InstAddrBus` = 32).
- `clk`  in  1  core clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low (asserted when 0)
- `if_req`  in  1  fetch wants the memory port
- `mem_req`  in  1  MEM stage has a load/store in flight
- `id_stallreq`  in  1  load-use hazard detected in ID
- `ex_branch`  in  1  taken branch/jump resolved in EX
- `port_done`  in  1  memory port completes the current access this cycle
- `port_req`  out  1  memory port access active (registered)
- `port_sel`  out  1  0 = IF owns port, 1 = MEM owns port (registered)
- `if_done`  out  1  fetch data valid this cycle
- `mem_done`  out  1  load/store complete this cycle
- `stall`  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB
- `flush`  out  1  clear IF/ID and ID/EX this cycle

## Operation
- Port FSM states: IDLE, FETCH, MEMOP.
  - IDLE → MEMOP if `mem_req`.
  - Otherwise IDLE → FETCH if `if_req`.
  - MEM has priority over IF.
- FETCH/MEMOP hold until `port_done`, then return to IDLE. No preemption: a `mem_req` arriving during FETCH waits.
- `port_req` = state ≠ IDLE. `port_sel` = (state == MEMOP).
- `mem_done` = MEMOP && `port_done`.
- `if_done` = FETCH && `port_done` && !`kill`.
- `kill` register:
  - Set when `flush` fires while state is FETCH, or when it fires in the same cycle IDLE→FETCH is taken.
  - Cleared when that fetch's `port_done` arrives.
  - The killed fetch completes on the port, but its data is dropped.
- Stall vector, highest priority first:
  - `mem_req` && !`mem_done` → 6'b011111 (MEM/WB inserts a bubble).
  - `id_stallreq` → 6'b000111 (ID/EX bubble).
  - `if_req` && !`if_done` → 6'b000011.
  - else → 6'b000000.
- `flush` = `ex_branch` && !`stall[3]`. A branch held in EX by a MEM stall flushes only once EX/MEM is released.
- `flush` and a simultaneous `id_stallreq`: `flush` wins for IF/ID and ID/EX; `stall` still shows 6'b000111.

## Timing
- All registered state (FSM, `kill`, `port_req`, `port_sel`) resets to IDLE/0 asynchronously.
- While `rst` = 0, all outputs are 0.
- Request in cycle n with FSM in IDLE → `port_req` high from n+1.
- `port_done` in cycle m → `if_done`/`mem_done` in m (combinational), `port_req` low in m+1.
- There is one mandatory IDLE cycle between accesses; back-to-back throughput is done-latency + 1.
- `stall` and `flush` are combinational from state and inputs; there is no added latency.
- Reset asserted mid-access: the FSM returns to IDLE immediately and the outstanding `port_done` is ignored. The memory controller is reset by the same `rst`.

## Configuration
- `PIPE_CTRL_PERF_CNT_EN` defined adds two outputs:
  - `stall_cycles` (32 bit): counts cycles with `stall[0]` set.
  - `flush_count` (32 bit): counts `flush` pulses.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- `PIPE_CTRL_PERF_CNT_EN` undefined: the counters and their ports are absent; all other behaviour is identical.

## Structure
- Shared defines file holds:
  - FSM state encodings `PORT_IDLE`, `PORT_FETCH`, `PORT_MEMOP`.
  - Stall constants `STALL_NONE`, `STALL_IF` (6'b000011), `STALL_ID` (6'b000111), `STALL_MEM` (6'b011111).
- One sub-module, `mem_port_arb`, contains the FSM, the `kill` register and the done outputs. `pipe_ctrl` contains the stall/flush logic and the optional counters.

## Test plan
- Reset, then `if_req`=1 with `port_done` 3 cycles after `port_req` → `stall`=000011 until `if_done` pulses once; `port_req` low the next cycle.
- `if_req` and `mem_req` both high in IDLE → `port_sel`=1 first and `stall`=011111 until `mem_done`; then one IDLE cycle; then FETCH.
- `mem_req` raised during FETCH → fetch completes (`if_done`); MEMOP starts 2 cycles later; `stall`=011111 throughout.
- `ex_branch` during FETCH → `flush`=1 for one cycle; the subsequent `port_done` gives `if_done`=0; the next fetch is delivered normally.
- `ex_branch` while `mem_req` pending → `flush` stays 0 until the cycle `mem_done` fires, then `flush`=1.
- With `PIPE_CTRL_PERF_CNT_EN`: 10 stalled cycles and 2 flushes → `stall_cycles`=10, `flush_count`=2; `rst`=0 mid-access → all outputs 0, FSM IDLE.
